// File: rtl/gj_axis_uart_pkg.sv
// rtl/gj_axis_uart_pkg.sv - shared UART AXIS constants and types
package gj_axis_uart_pkg;

  localparam int UART_DATA_W    = 8;
  // Default buffer depth (log2), shared with the TX-side buffer.
  localparam int DEFAULT_ADDR_W = 10;

  typedef enum logic {
    ACCEPT  = 1'b0,
    DISCARD = 1'b1
  } wr_state_t;

endpackage

// File: rtl/gj_sdp_ram.sv
// rtl/gj_sdp_ram.sv - simple dual-port RAM, registered read, no array reset
module gj_sdp_ram #(
  parameter int WIDTH  = 9,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/gj_axis_uart_rx_pkt_fifo.sv
// rtl/gj_axis_uart_rx_pkt_fifo.sv - store-and-forward packet FIFO after UART rx
module gj_axis_uart_rx_pkt_fifo
  import gj_axis_uart_pkg::*;
#(
  parameter int DATA_W = UART_DATA_W,
  parameter int ADDR_W = DEFAULT_ADDR_W,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_tvalid,
  input  logic [DATA_W-1:0] in_tdata,
  input  logic              in_tlast,
  output logic              out_tvalid,
  input  logic              out_tready,
  output logic [DATA_W-1:0] out_tdata,
  output logic              out_tlast,
  output logic [CNT_W-1:0]  pkt_avail,
  output logic [ADDR_W:0]   level,
  output logic [CNT_W-1:0]  drop_cnt,
  output logic              overflow
);

  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

  wr_state_t         state, state_nxt;
  logic [ADDR_W:0]   wr_ptr, wr_commit, rd_ptr, used;
  logic              full, ram_we, commit, rewind, drop;
  logic              valid_r, load, pkt_inc, pkt_dec;
  logic [DATA_W:0]   ram_q;

  // Space is judged against the registered rd_ptr only.
  assign used  = wr_ptr - rd_ptr;
  assign full  = (used == DEPTH);
  assign level = used;

  always_comb begin
    state_nxt = state;
    ram_we    = 1'b0;
    commit    = 1'b0;
    rewind    = 1'b0;
    drop      = 1'b0;
    case (state)
      ACCEPT: begin
        if (in_tvalid) begin
          if (!full) begin
            ram_we = 1'b1;
            commit = in_tlast;
          end else begin
            rewind = 1'b1;
            if (in_tlast) drop = 1'b1;
            else          state_nxt = DISCARD;
          end
        end
      end
      DISCARD: begin
        if (in_tvalid && in_tlast) begin
          drop      = 1'b1;
          state_nxt = ACCEPT;
        end
      end
      default: state_nxt = ACCEPT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state     <= ACCEPT;
      wr_ptr    <= '0;
      wr_commit <= '0;
    end else begin
      state <= state_nxt;
      if (ram_we) wr_ptr <= wr_ptr + 1'b1;
      if (commit) wr_commit <= wr_ptr + 1'b1;
      if (rewind) wr_ptr <= wr_commit;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt <= '0;
      overflow <= 1'b0;
    end else if (flush) begin
      overflow <= 1'b0;
    end else begin
      overflow <= drop;
      if (drop && drop_cnt != {CNT_W{1'b1}}) drop_cnt <= drop_cnt + 1'b1;
    end
  end

  // The RAM read register doubles as the output register; it only
  // advances on a load, so data holds during a stall.
  assign load = (!valid_r || out_tready) && (rd_ptr != wr_commit);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr  <= '0;
      valid_r <= 1'b0;
    end else if (load) begin
      rd_ptr  <= rd_ptr + 1'b1;
      valid_r <= 1'b1;
    end else if (out_tready) begin
      valid_r <= 1'b0;
    end
  end

  gj_sdp_ram #(
    .WIDTH  (DATA_W + 1),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we && !flush),
    .waddr (wr_ptr[ADDR_W-1:0]),
    .wdata ({in_tlast, in_tdata}),
    .re    (load),
    .raddr (rd_ptr[ADDR_W-1:0]),
    .rdata (ram_q)
  );

  assign out_tvalid = valid_r;
  assign out_tdata  = valid_r ? ram_q[DATA_W-1:0] : '0;
  assign out_tlast  = valid_r & ram_q[DATA_W];

  assign pkt_inc = commit && !flush;
  assign pkt_dec = valid_r && out_tready && out_tlast;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      pkt_avail <= '0;
    end else if (pkt_inc && !pkt_dec) begin
      pkt_avail <= pkt_avail + 1'b1;
    end else if (!pkt_inc && pkt_dec) begin
      pkt_avail <= pkt_avail - 1'b1;
    end
  end

endmodule

// File: tb/tb_gj_axis_uart_rx_pkt_fifo.sv
// tb/tb_gj_axis_uart_rx_pkt_fifo.sv - directed self-checking bench, depth 16
module tb_gj_axis_uart_rx_pkt_fifo;

  logic        clk = 1'b0;
  logic        rst, flush;
  logic        in_tvalid, in_tlast, out_tready;
  logic [7:0]  in_tdata;
  logic        out_tvalid, out_tlast, overflow;
  logic [7:0]  out_tdata;
  logic [15:0] pkt_avail, drop_cnt;
  logic [4:0]  level;

  int total = 0;
  int bad   = 0;

  logic [7:0] got_q[$];
  logic       last_q[$];

  always #5 clk = ~clk;

  gj_axis_uart_rx_pkt_fifo #(.DATA_W(8), .ADDR_W(4), .CNT_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_tvalid  (in_tvalid),
    .in_tdata   (in_tdata),
    .in_tlast   (in_tlast),
    .out_tvalid (out_tvalid),
    .out_tready (out_tready),
    .out_tdata  (out_tdata),
    .out_tlast  (out_tlast),
    .pkt_avail  (pkt_avail),
    .level      (level),
    .drop_cnt   (drop_cnt),
    .overflow   (overflow)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic l);
    in_tvalid = 1'b1;
    in_tdata  = d;
    in_tlast  = l;
    tick();
    in_tvalid = 1'b0;
    in_tlast  = 1'b0;
  endtask

  task automatic drain(input int cycles);
    got_q.delete();
    last_q.delete();
    out_tready = 1'b1;
    repeat (cycles) begin
      if (out_tvalid) begin
        got_q.push_back(out_tdata);
        last_q.push_back(out_tlast);
      end
      tick();
    end
    out_tready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_tvalid = 1'b0; in_tdata = 8'h00;
    in_tlast = 1'b0; out_tready = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    total++; if (out_tvalid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b want=0", out_tvalid); end
    total++; if (out_tdata !== 8'h00) begin bad++; $display("FAIL reset_tdata got=%h want=00", out_tdata); end
    total++; if (out_tlast !== 1'b0) begin bad++; $display("FAIL reset_tlast got=%0b want=0", out_tlast); end
    total++; if (level !== 5'd0) begin bad++; $display("FAIL reset_level got=%0d want=0", level); end
    total++; if (pkt_avail !== 16'd0) begin bad++; $display("FAIL reset_pkt_avail got=%0d want=0", pkt_avail); end
    total++; if (drop_cnt !== 16'd0) begin bad++; $display("FAIL reset_drop_cnt got=%0d want=0", drop_cnt); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow got=%0b want=0", overflow); end
  endtask

  task automatic test_basic();
    out_tready = 1'b1;
    for (int i = 0; i < 5; i++) send_byte(8'(8'h11 + i), i == 4);
    total++; if (out_tvalid !== 1'b0) begin bad++; $display("FAIL basic_latency_n1 got=%0b want=0", out_tvalid); end
    total++; if (pkt_avail !== 16'd1) begin bad++; $display("FAIL basic_pkt_avail1 got=%0d want=1", pkt_avail); end
    tick();
    for (int j = 0; j < 5; j++) begin
      total++; if (out_tvalid !== 1'b1) begin bad++; $display("FAIL basic_valid[%0d] got=%0b want=1", j, out_tvalid); end
      total++; if (out_tdata !== 8'(8'h11 + j)) begin bad++; $display("FAIL basic_data[%0d] got=%h want=%h", j, out_tdata, 8'(8'h11 + j)); end
      total++; if (out_tlast !== (j == 4)) begin bad++; $display("FAIL basic_last[%0d] got=%0b want=%0b", j, out_tlast, j == 4); end
      tick();
    end
    total++; if (out_tvalid !== 1'b0) begin bad++; $display("FAIL basic_valid_end got=%0b want=0", out_tvalid); end
    total++; if (pkt_avail !== 16'd0) begin bad++; $display("FAIL basic_pkt_avail0 got=%0d want=0", pkt_avail); end
    out_tready = 1'b0;
  endtask

  task automatic test_overflow();
    int ov_cnt = 0;
    logic ov_at_last = 1'b0;
    out_tready = 1'b0;
    for (int i = 0; i < 10; i++) send_byte(8'(8'h20 + i), i == 9);
    total++; if (level !== 5'd10) begin bad++; $display("FAIL ovf_level_commit got=%0d want=10", level); end
    total++; if (pkt_avail !== 16'd1) begin bad++; $display("FAIL ovf_pkt_avail got=%0d want=1", pkt_avail); end
    for (int i = 0; i < 8; i++) begin
      send_byte(8'(8'h30 + i), i == 7);
      if (overflow) ov_cnt++;
      if (i == 7) ov_at_last = overflow;
    end
    tick();
    if (overflow) ov_cnt++;
    total++; if (ov_at_last !== 1'b1) begin bad++; $display("FAIL ovf_pulse_at_tlast got=%0b want=1", ov_at_last); end
    total++; if (ov_cnt != 1) begin bad++; $display("FAIL ovf_pulse_count got=%0d want=1", ov_cnt); end
    total++; if (drop_cnt !== 16'd1) begin bad++; $display("FAIL ovf_drop_cnt got=%0d want=1", drop_cnt); end
    // One of the ten bytes already sits in the output register.
    total++; if (level !== 5'd9) begin bad++; $display("FAIL ovf_level got=%0d want=9", level); end
    total++; if (out_tdata !== 8'h20 || out_tvalid !== 1'b1) begin bad++; $display("FAIL ovf_head got=%h/%0b want=20/1", out_tdata, out_tvalid); end
    drain(20);
    total++; if (got_q.size() != 10) begin bad++; $display("FAIL ovf_read_count got=%0d want=10", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < 10; i++) begin
      total++; if (got_q[i] !== 8'(8'h20 + i) || last_q[i] !== (i == 9)) begin bad++; $display("FAIL ovf_read[%0d] got=%h/%0b want=%h/%0b", i, got_q[i], last_q[i], 8'(8'h20 + i), i == 9); end
    end
  endtask

  task automatic test_long_pkt();
    out_tready = 1'b0;
    for (int i = 0; i < 20; i++) send_byte(8'(8'h90 + i), i == 19);
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL long_overflow got=%0b want=1", overflow); end
    total++; if (drop_cnt !== 16'd2) begin bad++; $display("FAIL long_drop_cnt got=%0d want=2", drop_cnt); end
    total++; if (level !== 5'd0) begin bad++; $display("FAIL long_level got=%0d want=0", level); end
    total++; if (pkt_avail !== 16'd0) begin bad++; $display("FAIL long_pkt_avail got=%0d want=0", pkt_avail); end
    tick();
    total++; if (out_tvalid !== 1'b0) begin bad++; $display("FAIL long_valid got=%0b want=0", out_tvalid); end
    for (int i = 0; i < 3; i++) send_byte(8'(8'hA0 + i), i == 2);
    drain(10);
    total++; if (got_q.size() != 3) begin bad++; $display("FAIL long_next_count got=%0d want=3", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < 3; i++) begin
      total++; if (got_q[i] !== 8'(8'hA0 + i) || last_q[i] !== (i == 2)) begin bad++; $display("FAIL long_next[%0d] got=%h/%0b want=%h/%0b", i, got_q[i], last_q[i], 8'(8'hA0 + i), i == 2); end
    end
  endtask

  task automatic test_back_to_back();
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data  = 8'h00;
    logic       prev_last  = 1'b0;
    logic       avail_bad  = 1'b0;
    got_q.delete();
    last_q.delete();
    for (int c = 0; c < 50; c++) begin
      in_tvalid  = (c < 15);
      in_tdata   = 8'(8'h60 + c);
      in_tlast   = (c < 15) && (c % 3 == 2);
      out_tready = (c % 2 == 0);
      if (out_tvalid && prev_stall) begin
        total++; if (out_tdata !== prev_data || out_tlast !== prev_last) begin bad++; $display("FAIL b2b_stall_stable c=%0d got=%h/%0b want=%h/%0b", c, out_tdata, out_tlast, prev_data, prev_last); end
      end
      if (pkt_avail > 16'd5) avail_bad = 1'b1;
      if (out_tvalid && out_tready) begin
        got_q.push_back(out_tdata);
        last_q.push_back(out_tlast);
      end
      prev_stall = out_tvalid && !out_tready;
      prev_data  = out_tdata;
      prev_last  = out_tlast;
      tick();
    end
    in_tvalid = 1'b0; in_tlast = 1'b0; out_tready = 1'b0;
    total++; if (avail_bad !== 1'b0) begin bad++; $display("FAIL b2b_pkt_avail_range got=%0b want=0", avail_bad); end
    total++; if (got_q.size() != 15) begin bad++; $display("FAIL b2b_count got=%0d want=15", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < 15; i++) begin
      total++; if (got_q[i] !== 8'(8'h60 + i) || last_q[i] !== (i % 3 == 2)) begin bad++; $display("FAIL b2b_byte[%0d] got=%h/%0b want=%h/%0b", i, got_q[i], last_q[i], 8'(8'h60 + i), i % 3 == 2); end
    end
    total++; if (pkt_avail !== 16'd0) begin bad++; $display("FAIL b2b_pkt_avail_end got=%0d want=0", pkt_avail); end
    total++; if (drop_cnt !== 16'd2) begin bad++; $display("FAIL b2b_drop_cnt got=%0d want=2", drop_cnt); end
  endtask

  task automatic test_full_boundary();
    out_tready = 1'b0;
    for (int i = 0; i < 16; i++) send_byte(8'(8'h40 + i), i == 15);
    // Prefetch read is issued this cycle; the registered rd_ptr still says full.
    send_byte(8'h50, 1'b1);
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL full_overflow got=%0b want=1", overflow); end
    total++; if (drop_cnt !== 16'd3) begin bad++; $display("FAIL full_drop_cnt got=%0d want=3", drop_cnt); end
    total++; if (level !== 5'd15) begin bad++; $display("FAIL full_level got=%0d want=15", level); end
    total++; if (pkt_avail !== 16'd1) begin bad++; $display("FAIL full_pkt_avail got=%0d want=1", pkt_avail); end
    drain(25);
    total++; if (got_q.size() != 16) begin bad++; $display("FAIL full_read_count got=%0d want=16", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < 16; i++) begin
      total++; if (got_q[i] !== 8'(8'h40 + i) || last_q[i] !== (i == 15)) begin bad++; $display("FAIL full_read[%0d] got=%h/%0b want=%h/%0b", i, got_q[i], last_q[i], 8'(8'h40 + i), i == 15); end
    end
  endtask

  task automatic test_flush();
    out_tready = 1'b0;
    send_byte(8'h70, 1'b0);
    send_byte(8'h71, 1'b1);
    send_byte(8'h72, 1'b0);
    send_byte(8'h73, 1'b1);
    send_byte(8'h74, 1'b0);
    total++; if (pkt_avail !== 16'd2) begin bad++; $display("FAIL flush_pre_avail got=%0d want=2", pkt_avail); end
    total++; if (out_tvalid !== 1'b1) begin bad++; $display("FAIL flush_pre_valid got=%0b want=1", out_tvalid); end
    flush = 1'b1;
    send_byte(8'h75, 1'b0);
    flush = 1'b0;
    total++; if (out_tvalid !== 1'b0) begin bad++; $display("FAIL flush_valid got=%0b want=0", out_tvalid); end
    total++; if (pkt_avail !== 16'd0) begin bad++; $display("FAIL flush_pkt_avail got=%0d want=0", pkt_avail); end
    total++; if (level !== 5'd0) begin bad++; $display("FAIL flush_level got=%0d want=0", level); end
    total++; if (drop_cnt !== 16'd3) begin bad++; $display("FAIL flush_drop_cnt got=%0d want=3", drop_cnt); end
    for (int i = 0; i < 3; i++) send_byte(8'(8'h80 + i), i == 2);
    drain(10);
    total++; if (got_q.size() != 3) begin bad++; $display("FAIL flush_next_count got=%0d want=3", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < 3; i++) begin
      total++; if (got_q[i] !== 8'(8'h80 + i) || last_q[i] !== (i == 2)) begin bad++; $display("FAIL flush_next[%0d] got=%h/%0b want=%h/%0b", i, got_q[i], last_q[i], 8'(8'h80 + i), i == 2); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_long_pkt();
    test_back_to_back();
    test_full_boundary();
    test_flush();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gj_axis_uart_rx_pkt_fifo.md
Name: gj_axis_uart_rx_pkt_fifo

Overview:
- Store-and-forward packet FIFO directly downstream of the UART receive path.
- Consumes the rx AXIS stream (tvalid/tdata/tlast, no backpressure) produced by the UART top, where tlast is set by the max-bytes / max-gap framing logic.
- Buffers whole packets and presents them to the system on a full AXIS master with tready.
- A packet becomes visible only after its tlast byte is stored. Packets that cannot fit are dropped whole and counted.

Parameters:
- DATA_W, 8, byte width of tdata.
- ADDR_W, 10, log2 of the FIFO depth. Default depth is 1024 bytes.
- CNT_W, 16, width of the drop and packet counters.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  synchronous clear of the FIFO contents; counters are kept.
- in_tvalid  in  1  byte strobe from the UART rx packetiser. It cannot be stalled.
- in_tdata  in  DATA_W  received byte.
- in_tlast  in  1  last byte of the packet.
- out_tvalid  out  1  AXIS master valid.
- out_tready  in  1  AXIS master ready.
- out_tdata  out  DATA_W  output byte.
- out_tlast  out  1  last byte of the packet.
- pkt_avail  out  CNT_W  number of complete packets stored and not yet fully read.
- level  out  ADDR_W+1  number of bytes in RAM, committed plus in-progress, excluding the output register.
- drop_cnt  out  CNT_W  dropped-packet counter. Saturates at all-ones.
- overflow  out  1  one-cycle pulse when a packet is dropped.

Behaviour:
- Storage: RAM of (DATA_W+1) bits by 2^ADDR_W words; the extra bit stores tlast. Pointers are ADDR_W+1 bits and wrap naturally.
  - wr_ptr: write pointer for the packet in progress.
  - wr_commit: end of the last complete packet.
  - rd_ptr: read pointer.
- Free space = 2^ADDR_W − (wr_ptr − rd_ptr). Every free word is usable: full is free==0, empty is rd_ptr==wr_commit.
- Write FSM with states ACCEPT and DISCARD.
  - ACCEPT, in_tvalid, free>0: write the byte and increment wr_ptr. If in_tlast, set wr_commit to the new wr_ptr on the same edge.
  - ACCEPT, in_tvalid, free==0: the byte is not written and wr_ptr is rewound to wr_commit.
    - If in_tlast is set: pulse overflow, increment drop_cnt, stay in ACCEPT.
    - Otherwise: go to DISCARD.
  - DISCARD: every byte is ignored. On in_tvalid&in_tlast: pulse overflow, increment drop_cnt, return to ACCEPT.
  - A packet longer than 2^ADDR_W bytes is therefore always dropped.
- Read side: one-cycle registered RAM read feeding a single output register (prefetch).
  - The output register loads when it is empty, or when the current byte is taken, and rd_ptr != wr_commit.
  - out_tdata and out_tlast are stable while out_tvalid&!out_tready.
- Latency: tlast is written in cycle N; wr_commit is visible in N+1; out_tvalid rises in cycle N+2 if the FIFO and the output register were empty.
- Throughput: with out_tready held at 1, one byte per cycle.
- pkt_avail:
  - +1 on a committed tlast.
  - −1 on the handshake of a byte with out_tlast=1.
  - Both in the same cycle leaves it unchanged.
- Simultaneous write and read: both are legal. Free space is computed from the registered rd_ptr, so a read in the same cycle does not free space for that cycle's write.
- rst: all pointers, pkt_avail and drop_cnt go to 0; FSM goes to ACCEPT; out_tvalid=0, out_tdata=0, out_tlast=0, overflow=0, level=0.
- flush: same as rst except drop_cnt is kept. A packet in progress is lost and not counted. A byte arriving in the flush cycle is discarded.
- Reset or flush in the middle of a read burst: out_tvalid drops in the next cycle, even if out_tready is low. This AXIS violation is permitted only under reset/flush.

Decomposition:
- Shared package gj_axis_uart_pkg holds:
  - the UART byte width constant (8);
  - the write-state enumeration (ACCEPT, DISCARD);
  - a default-depth constant reused by the TX-side buffer.
- One sub-module, gj_sdp_ram: simple dual-port RAM with a synchronous write port, a registered read port, and no reset on the array, so it can be inferred as block RAM.

Test Plan:
- Reset, then a 5-byte packet 0x11..0x15 with tlast on 0x15, out_tready=1 → out_tvalid rises 2 cycles after tlast; bytes 0x11..0x15 on consecutive cycles, tlast only on 0x15; pkt_avail goes 1→0.
- ADDR_W=4 (depth 16), out_tready=0, packets of 10 bytes then 8 bytes → first packet stored, second dropped; overflow pulses once at the second tlast; drop_cnt=1; level=10; later reading yields only the 10 bytes.
- ADDR_W=4, single 20-byte packet → dropped; drop_cnt=1; level=0; pkt_avail=0; the next 3-byte packet is received intact.
- Continuous back-to-back 3-byte packets with out_tready toggling 1,0,1,0 → no loss and no reordering; tdata stable during stalls; pkt_avail never negative.
- Exactly 16 bytes into depth 16, then a 1-byte packet while reading starts in the same cycle → first packet fits (full boundary); the 1-byte packet is dropped because free space comes from the registered rd_ptr.
- flush asserted mid-packet with 2 complete packets stored → out_tvalid=0 next cycle; pkt_avail=0; drop_cnt unchanged; the following packet is received normally.
